julia_fb_scanout: RTL and testbench

- Read side of the Julia frame buffer. Generates 1280x720 raster timing and produces read addresses for port B of the 4-bit/pixel BRAM.
- Compensates for BRAM read latency and maps each 4-bit code to 24-bit RGB.
- Emits hsync/vsync/de aligned to the pixel data for the HDMI encoder. It replaces the external sx/sy supply on the display side.

---
 rtl/julia_video_pkg.sv | 52 +++++
 rtl/julia_video_timing.sv | 109 ++++++++++
 rtl/julia_fb_scanout.sv | 185 ++++++++++++++++++
 tb/tb_julia_fb_scanout.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/julia_video_pkg.sv
// julia_video_pkg: shared constants and types for the Julia frame-buffer
// display path.
// It holds the 720p raster timing constants, the scan state encoding, the
// timing tag that is carried down the read-latency delay line, and the
// code-to-colour helpers.
// Build option: define JULIA_SCANOUT_PALETTE_EN to add the 16-entry colour
// palette. Without it the display path uses greyscale replication.
package julia_video_pkg;

    // 1280x720 raster, pixel clock timing
    localparam int H_RES_720P  = 1280;
    localparam int H_FP_720P   = 110;
    localparam int H_SYNC_720P = 40;
    localparam int H_BP_720P   = 220;
    localparam int V_RES_720P  = 720;
    localparam int V_FP_720P   = 5;
    localparam int V_SYNC_720P = 5;
    localparam int V_BP_720P   = 20;

    // Scan control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_e;

    // Per-pixel timing tag carried alongside the BRAM read
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic first;
    } timing_t;

    localparam timing_t TIMING_IDLE = '{active: 1'b0, hsync: 1'b0, vsync: 1'b0, first: 1'b0};

    // Replicate the 4-bit code into each nibble: 0 -> 0x00, 15 -> 0xFF
    function automatic logic [23:0] grey_rgb(input logic [3:0] code);
        return {code, code, code, code, code, code};
    endfunction

`ifdef JULIA_SCANOUT_PALETTE_EN
    // Blue -> cyan -> yellow -> white ramp, indexed by iteration code
    localparam logic [23:0] PALETTE [0:15] = '{
        24'h000040, 24'h000080, 24'h0000C0, 24'h0000FF,
        24'h0040FF, 24'h0080FF, 24'h00C0FF, 24'h00FFFF,
        24'h40FFC0, 24'h80FF80, 24'hC0FF40, 24'hFFFF00,
        24'hFFFF55, 24'hFFFFAA, 24'hFFFFDD, 24'hFFFFFF
    };
`endif

endpackage

// File: rtl/julia_video_timing.sv
// julia_video_timing: horizontal/vertical raster counters for the scan-out
// path. Counters sit at the origin while run is low and free-run across the
// full line/frame totals while it is high. Stage-0 timing (active, syncs)
// is decoded from the counter registers and forced low while not running.
module julia_video_timing
    import julia_video_pkg::*;
#(
    parameter int H_RES  = H_RES_720P,
    parameter int H_FP   = H_FP_720P,
    parameter int H_SYNC = H_SYNC_720P,
    parameter int H_BP   = H_BP_720P,
    parameter int V_RES  = V_RES_720P,
    parameter int V_FP   = V_FP_720P,
    parameter int V_SYNC = V_SYNC_720P,
    parameter int V_BP   = V_BP_720P,
    parameter int HW     = $clog2(H_RES + H_FP + H_SYNC + H_BP),
    parameter int VW     = $clog2(V_RES + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          active,
    output logic          vactive,
    output logic          hsync,
    output logic          vsync,
    output logic          line_end,
    output logic          frame_end
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_RES_C    = HW'(H_RES);
    localparam logic [HW-1:0] HS_START_C = HW'(H_RES + H_FP);
    localparam logic [HW-1:0] HS_END_C   = HW'(H_RES + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ZERO_C   = {HW{1'b0}};
    localparam logic [HW-1:0] H_ONE_C    = HW'(1);

    localparam logic [VW-1:0] V_RES_C    = VW'(V_RES);
    localparam logic [VW-1:0] VS_START_C = VW'(V_RES + V_FP);
    localparam logic [VW-1:0] VS_END_C   = VW'(V_RES + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ZERO_C   = {VW{1'b0}};
    localparam logic [VW-1:0] V_ONE_C    = VW'(1);

    logic [HW-1:0] hcnt_r;
    logic [VW-1:0] vcnt_r;
    logic          line_end_s;
    logic          frame_end_s;

    assign hcnt = hcnt_r;
    assign vcnt = vcnt_r;

    // Line/frame end decode from the counter registers
    always_comb begin
        line_end_s  = 1'b0;
        frame_end_s = 1'b0;
        if (hcnt_r == H_LAST_C) begin
            line_end_s  = 1'b1;
            frame_end_s = (vcnt_r == V_LAST_C);
        end else begin
            line_end_s  = 1'b0;
            frame_end_s = 1'b0;
        end
    end

    // Raster counters: parked at the origin while idle, wrapping otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_r <= H_ZERO_C;
            vcnt_r <= V_ZERO_C;
        end else if (!run) begin
            hcnt_r <= H_ZERO_C;
            vcnt_r <= V_ZERO_C;
        end else if (line_end_s) begin
            hcnt_r <= H_ZERO_C;
            vcnt_r <= frame_end_s ? V_ZERO_C : (vcnt_r + V_ONE_C);
        end else begin
            hcnt_r <= hcnt_r + H_ONE_C;
            vcnt_r <= vcnt_r;
        end
    end

    // Stage-0 timing decode, suppressed while the scan is idle
    always_comb begin
        active  = 1'b0;
        vactive = 1'b0;
        hsync   = 1'b0;
        vsync   = 1'b0;
        if (run) begin
            vactive = (vcnt_r < V_RES_C);
            active  = (hcnt_r < H_RES_C) && (vcnt_r < V_RES_C);
            hsync   = (hcnt_r >= HS_START_C) && (hcnt_r < HS_END_C);
            vsync   = (vcnt_r >= VS_START_C) && (vcnt_r < VS_END_C);
        end else begin
            vactive = 1'b0;
            active  = 1'b0;
            hsync   = 1'b0;
            vsync   = 1'b0;
        end
    end

    assign line_end  = line_end_s;
    assign frame_end = frame_end_s;

endmodule

// File: rtl/julia_fb_scanout.sv
// julia_fb_scanout: read side of the Julia frame buffer.
// Drives 720p raster timing, issues port-B reads of the 4-bit/pixel BRAM,
// delays the timing tag by RD_LAT+1 cycles so hsync/vsync/de/frame_start
// line up with the registered colour, and maps each code to 24-bit RGB.
// Build option: JULIA_SCANOUT_PALETTE_EN selects the colour palette instead
// of greyscale replication; latency is the same either way.
module julia_fb_scanout
    import julia_video_pkg::*;
#(
    parameter int H_RES  = H_RES_720P,
    parameter int H_FP   = H_FP_720P,
    parameter int H_SYNC = H_SYNC_720P,
    parameter int H_BP   = H_BP_720P,
    parameter int V_RES  = V_RES_720P,
    parameter int V_FP   = V_FP_720P,
    parameter int V_SYNC = V_SYNC_720P,
    parameter int V_BP   = V_BP_720P,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [3:0]        rd_data,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_de,
    output logic [7:0]        o_red,
    output logic [7:0]        o_green,
    output logic [7:0]        o_blue,
    output logic              o_frame_start
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DEPTH   = RD_LAT + 1;

    localparam logic [ADDR_W-1:0] ADDR_ZERO_C = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] LINE_STEP_C = ADDR_W'(H_RES);

    scan_state_e       state_r;
    logic              run_s;
    logic [HW-1:0]     hcnt_s;
    logic [VW-1:0]     vcnt_s;
    logic              active_s;
    logic              vactive_s;
    logic              hsync_s;
    logic              vsync_s;
    logic              line_end_s;
    logic              frame_end_s;
    timing_t           stage0_s;
    timing_t           pipe_r [DEPTH];
    logic [ADDR_W-1:0] row_base_r;
    logic [23:0]       rgb_r;

    // Colour lookup for one 4-bit iteration code
    function automatic logic [23:0] map_code(input logic [3:0] code);
`ifdef JULIA_SCANOUT_PALETTE_EN
        return PALETTE[code];
`else
        return grey_rgb(code);
`endif
    endfunction

    assign run_s = (state_r != ST_IDLE);

    julia_video_timing #(
        .H_RES  (H_RES),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_RES  (V_RES),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP),
        .HW     (HW),
        .VW     (VW)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .run       (run_s),
        .hcnt      (hcnt_s),
        .vcnt      (vcnt_s),
        .active    (active_s),
        .vactive   (vactive_s),
        .hsync     (hsync_s),
        .vsync     (vsync_s),
        .line_end  (line_end_s),
        .frame_end (frame_end_s)
    );

    // Scan control: start on en, and once en drops let the current frame finish
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en) state_r <= ST_RUN;
                    else    state_r <= ST_IDLE;
                end
                ST_RUN: begin
                    if (frame_end_s) state_r <= en ? ST_RUN : ST_IDLE;
                    else if (!en)    state_r <= ST_DRAIN;
                    else             state_r <= ST_RUN;
                end
                ST_DRAIN: begin
                    if (frame_end_s) state_r <= en ? ST_RUN : ST_IDLE;
                    else             state_r <= ST_DRAIN;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Row base: steps by one line of pixels after each active line, so the
    // address needs only an adder; cleared at frame wrap and while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_base_r <= ADDR_ZERO_C;
        end else if (!run_s || frame_end_s) begin
            row_base_r <= ADDR_ZERO_C;
        end else if (line_end_s && vactive_s) begin
            row_base_r <= row_base_r + LINE_STEP_C;
        end else begin
            row_base_r <= row_base_r;
        end
    end

    assign rd_en   = active_s;
    assign rd_addr = row_base_r + ADDR_W'(hcnt_s);

    // Stage-0 timing tag; the first-pixel flag only fires in a running frame
    always_comb begin
        stage0_s        = TIMING_IDLE;
        stage0_s.active = active_s;
        stage0_s.hsync  = hsync_s;
        stage0_s.vsync  = vsync_s;
        if ((state_r == ST_RUN) && (hcnt_s == {HW{1'b0}}) && (vcnt_s == {VW{1'b0}})) begin
            stage0_s.first = 1'b1;
        end else begin
            stage0_s.first = 1'b0;
        end
    end

    // Timing delay line: covers the BRAM read latency plus the colour register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_r[i] <= TIMING_IDLE;
            end
        end else begin
            pipe_r[0] <= stage0_s;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Colour register: captures read data in the cycle it is valid; blank otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_r <= 24'h000000;
        end else if (pipe_r[RD_LAT-1].active) begin
            rgb_r <= map_code(rd_data);
        end else begin
            rgb_r <= 24'h000000;
        end
    end

    assign o_de          = pipe_r[DEPTH-1].active;
    assign o_hsync       = pipe_r[DEPTH-1].hsync;
    assign o_vsync       = pipe_r[DEPTH-1].vsync;
    assign o_frame_start = pipe_r[DEPTH-1].first;
    assign o_red         = rgb_r[23:16];
    assign o_green       = rgb_r[15:8];
    assign o_blue        = rgb_r[7:0];

endmodule

// File: tb/tb_julia_fb_scanout.sv
// tb_julia_fb_scanout: directed bench for the frame-buffer scan-out.
// Two instances on a reduced raster (8x4 active, 16x8 total) with RD_LAT=1
// and RD_LAT=2 share clock/reset/enable; each has its own BRAM model that
// returns addr[3:0] after the configured latency.
module tb_julia_fb_scanout;

    localparam int H_RES  = 8;
    localparam int H_FP   = 2;
    localparam int H_SYNC = 3;
    localparam int H_BP   = 3;
    localparam int V_RES  = 4;
    localparam int V_FP   = 1;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 1;
    localparam int ADDR_W = 20;

    logic clk;
    logic rst_n;
    logic en;

    logic              rd_en1, rd_en2;
    logic [ADDR_W-1:0] rd_addr1, rd_addr2;
    logic [3:0]        rd_data1, rd_data2, b2_stage;
    logic              hs1, vs1, de1, fs1, hs2, vs2, de2, fs2;
    logic [7:0]        r1, g1, b1, r2, g2, b2;
    logic [23:0]       rgb1, rgb2;

    int n_cmp;
    int n_bad;

    assign rgb1 = {r1, g1, b1};
    assign rgb2 = {r2, g2, b2};

    julia_fb_scanout #(
        .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .RD_LAT(1), .ADDR_W(ADDR_W)
    ) dut1 (
        .clk(clk), .rst(rst_n), .en(en),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .o_hsync(hs1), .o_vsync(vs1), .o_de(de1),
        .o_red(r1), .o_green(g1), .o_blue(b1), .o_frame_start(fs1)
    );

    julia_fb_scanout #(
        .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .RD_LAT(2), .ADDR_W(ADDR_W)
    ) dut2 (
        .clk(clk), .rst(rst_n), .en(en),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .o_hsync(hs2), .o_vsync(vs2), .o_de(de2),
        .o_red(r2), .o_green(g2), .o_blue(b2), .o_frame_start(fs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM models: data = addr[3:0], one and two cycles after the address
    always @(posedge clk) begin
        rd_data1 <= rd_addr1[3:0];
        b2_stage <= rd_addr2[3:0];
        rd_data2 <= b2_stage;
    end

    function automatic logic [23:0] exp_rgb(input int code);
`ifdef JULIA_SCANOUT_PALETTE_EN
        case (code)
            0:  return 24'h000040;  1:  return 24'h000080;
            2:  return 24'h0000C0;  3:  return 24'h0000FF;
            4:  return 24'h0040FF;  5:  return 24'h0080FF;
            6:  return 24'h00C0FF;  7:  return 24'h00FFFF;
            8:  return 24'h40FFC0;  9:  return 24'h80FF80;
            10: return 24'hC0FF40;  11: return 24'hFFFF00;
            12: return 24'hFFFF55;  13: return 24'hFFFFAA;
            14: return 24'hFFFFDD;  15: return 24'hFFFFFF;
            default: return 24'h000000;
        endcase
`else
        logic [7:0] g;
        g = 8'(code * 17);
        return {g, g, g};
`endif
    endfunction

    // Hold reset, then release with en=1 at a falling edge; scan starts next edge
    task automatic start_scan();
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rd_en1, rd_addr1, hs1, vs1, de1, rgb1, fs1} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs_lat1: got %0h required 0", {rd_en1, rd_addr1, hs1, vs1, de1, rgb1, fs1});
        end
        n_cmp++;
        if ({rd_en2, rd_addr2, hs2, vs2, de2, rgb2, fs2} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs_lat2: got %0h required 0", {rd_en2, rd_addr2, hs2, vs2, de2, rgb2, fs2});
        end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if ({rd_en1, rd_addr1, hs1, vs1, de1, rgb1, fs1, rd_en2, de2, fs2} !== '0) begin
            n_bad++;
            $display("FAIL idle_hold: outputs %0h required 0 with en=0", {rd_en1, rd_addr1, hs1, vs1, de1, rgb1, fs1});
        end
    endtask

    task automatic test_latency();
        int rc1, rc2, dc1, dc2, fc1, fc2;
        rc1 = -1; rc2 = -1; dc1 = -1; dc2 = -1; fc1 = -1; fc2 = -1;
        start_scan();
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rd_en1 && rc1 < 0) rc1 = c;
            if (rd_en2 && rc2 < 0) rc2 = c;
            if (de1 && dc1 < 0) dc1 = c;
            if (de2 && dc2 < 0) dc2 = c;
            if (fs1 && fc1 < 0) fc1 = c;
            if (fs2 && fc2 < 0) fc2 = c;
        end
        n_cmp++;
        if (rc1 !== 1) begin n_bad++; $display("FAIL first_rd_en: cycle %0d required 1", rc1); end
        n_cmp++;
        if (dc1 - rc1 !== 2) begin n_bad++; $display("FAIL de_lag_lat1: %0d required 2", dc1 - rc1); end
        n_cmp++;
        if (dc2 - rc2 !== 3) begin n_bad++; $display("FAIL de_lag_lat2: %0d required 3", dc2 - rc2); end
        n_cmp++;
        if (fc1 !== dc1) begin n_bad++; $display("FAIL fs_align_lat1: fs cycle %0d required %0d", fc1, dc1); end
        n_cmp++;
        if (fc2 !== dc2) begin n_bad++; $display("FAIL fs_align_lat2: fs cycle %0d required %0d", fc2, dc2); end
    endtask

    task automatic test_pixels();
        int n1, n2;
        n1 = 0; n2 = 0;
        start_scan();
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            n_cmp++;
            if (de1) begin
                if (rgb1 !== exp_rgb(n1 % 16)) begin
                    n_bad++;
                    $display("FAIL pixel_lat1[%0d]: got %06h required %06h", n1, rgb1, exp_rgb(n1 % 16));
                end
                n1++;
            end else if (rgb1 !== 24'h000000) begin
                n_bad++;
                $display("FAIL blank_lat1 cycle %0d: got %06h required 000000", c, rgb1);
            end
            n_cmp++;
            if (de2) begin
                if (rgb2 !== exp_rgb(n2 % 16)) begin
                    n_bad++;
                    $display("FAIL pixel_lat2[%0d]: got %06h required %06h", n2, rgb2, exp_rgb(n2 % 16));
                end
                n2++;
            end else if (rgb2 !== 24'h000000) begin
                n_bad++;
                $display("FAIL blank_lat2 cycle %0d: got %06h required 000000", c, rgb2);
            end
        end
        n_cmp++;
        if (n1 !== 32 || n2 !== 32) begin
            n_bad++;
            $display("FAIL pixel_count: got %0d/%0d required 32/32", n1, n2);
        end
    endtask

    task automatic test_addr();
        int n1, n2;
        n1 = 0; n2 = 0;
        start_scan();
        for (int c = 1; c <= 170; c++) begin
            @(negedge clk);
            if (rd_en1) begin
                n_cmp++;
                if (rd_addr1 !== ADDR_W'(n1 % 32)) begin
                    n_bad++;
                    $display("FAIL addr_lat1[%0d]: got %0d required %0d", n1, rd_addr1, n1 % 32);
                end
                n1++;
            end
            if (rd_en2) begin
                n_cmp++;
                if (rd_addr2 !== ADDR_W'(n2 % 32)) begin
                    n_bad++;
                    $display("FAIL addr_lat2[%0d]: got %0d required %0d", n2, rd_addr2, n2 % 32);
                end
                n2++;
            end
        end
        n_cmp++;
        if (n1 !== 56 || n2 !== 56) begin
            n_bad++;
            $display("FAIL rd_en_count: got %0d/%0d required 56/56", n1, n2);
        end
    endtask

    task automatic test_frame_timing();
        int w, de_n, hs_n, vs_n, fs_n, de_fall, hs_rise, vs_rise;
        logic de_prev, hs_prev, vs_prev;
        de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
        de_fall = -1; hs_rise = -1; vs_rise = -1;
        de_prev = 1'b0; hs_prev = 1'b0; vs_prev = 1'b0;
        start_scan();
        w = 0;
        while (fs1 !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        n_cmp++;
        if (fs1 !== 1'b1) begin n_bad++; $display("FAIL frame_sync: frame_start %b required 1 within 40 cycles", fs1); end
        for (int k = 0; k < 128; k++) begin
            if (k > 0) @(negedge clk);
            if (de1) de_n++;
            if (hs1) hs_n++;
            if (vs1) vs_n++;
            if (fs1) fs_n++;
            if (de_prev && !de1 && de_fall < 0) de_fall = k;
            if (!hs_prev && hs1 && hs_rise < 0) hs_rise = k;
            if (!vs_prev && vs1 && vs_rise < 0) vs_rise = k;
            de_prev = de1; hs_prev = hs1; vs_prev = vs1;
        end
        @(negedge clk);
        n_cmp++;
        if (de_n !== 32) begin n_bad++; $display("FAIL de_per_frame: got %0d required 32", de_n); end
        n_cmp++;
        if (hs_n !== 24) begin n_bad++; $display("FAIL hsync_per_frame: got %0d required 24", hs_n); end
        n_cmp++;
        if (vs_n !== 32) begin n_bad++; $display("FAIL vsync_per_frame: got %0d required 32", vs_n); end
        n_cmp++;
        if (hs_rise - de_fall !== 2) begin n_bad++; $display("FAIL hsync_offset: got %0d required 2", hs_rise - de_fall); end
        n_cmp++;
        if (vs_rise !== 80) begin n_bad++; $display("FAIL vsync_start: got %0d required 80", vs_rise); end
        n_cmp++;
        if (fs_n !== 1 || fs1 !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_period: pulses %0d next %b required 1 and 1", fs_n, fs1);
        end
    endtask

    task automatic test_drain();
        int w, de_n, fc1, fc2;
        logic bad;
        de_n = 0; fc1 = -1; fc2 = -1; bad = 1'b0;
        start_scan();
        w = 0;
        while (fs1 !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        n_cmp++;
        if (fs1 !== 1'b1) begin n_bad++; $display("FAIL drain_sync: frame_start %b required 1 within 40 cycles", fs1); end
        for (int k = 0; k < 128; k++) begin
            if (k > 0) @(negedge clk);
            if (de1) de_n++;
            if (k == 35) en = 1'b0;
        end
        n_cmp++;
        if (de_n !== 32) begin n_bad++; $display("FAIL drain_full_frame: de %0d required 32", de_n); end
        for (int k = 128; k <= 150; k++) begin
            @(negedge clk);
            if ({rd_en1, rd_addr1, hs1, vs1, de1, rgb1, fs1, rd_en2, rd_addr2, hs2, vs2, de2, rgb2, fs2} !== '0)
                bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin n_bad++; $display("FAIL drain_idle: outputs active %b required 0", bad); end
        en = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (fs1 && fc1 < 0) fc1 = c;
            if (fs2 && fc2 < 0) fc2 = c;
        end
        n_cmp++;
        if (fc1 !== 3) begin n_bad++; $display("FAIL restart_fs_lat1: cycle %0d required 3", fc1); end
        n_cmp++;
        if (fc2 !== 4) begin n_bad++; $display("FAIL restart_fs_lat2: cycle %0d required 4", fc2); end
    endtask

    task automatic test_async_reset();
        int w;
        start_scan();
        w = 0;
        while (fs1 !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (de1 !== 1'b1) begin n_bad++; $display("FAIL midline_de: got %b required 1", de1); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rd_en1, rd_addr1, hs1, vs1, de1, rgb1, fs1, rd_en2, rd_addr2, de2, rgb2, fs2} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: outputs %0h required 0", {rd_en1, rd_addr1, de1, rgb1, rd_en2, rd_addr2, de2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rd_en1 !== 1'b1 || rd_addr1 !== 20'd0) begin
            n_bad++;
            $display("FAIL restart_origin: rd_en %b addr %0d required 1 and 0", rd_en1, rd_addr1);
        end
        @(negedge clk);
        n_cmp++;
        if (rd_addr1 !== 20'd1) begin n_bad++; $display("FAIL restart_addr1: got %0d required 1", rd_addr1); end
        @(negedge clk);
        n_cmp++;
        if (fs1 !== 1'b1 || de1 !== 1'b1 || rgb1 !== exp_rgb(0)) begin
            n_bad++;
            $display("FAIL restart_first_pixel: fs %b de %b rgb %06h required 1 1 %06h", fs1, de1, rgb1, exp_rgb(0));
        end
        @(negedge clk);
        n_cmp++;
        if (fs1 !== 1'b0 || rgb1 !== exp_rgb(1)) begin
            n_bad++;
            $display("FAIL restart_second_pixel: fs %b rgb %06h required 0 %06h", fs1, rgb1, exp_rgb(1));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        test_reset();
        test_latency();
        test_pixels();
        test_addr();
        test_frame_timing();
        test_drain();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
